wn_pdcchrx_dmrsgen: RTL and testbench
=====================================

# wn_pdcchrx_dmrsgen

PDCCH receive DMRS sequence generator. The block accepts one configuration per PDCCH candidate and produces the Gold pseudo-random sequence c(n) of TS 38.211 §5.2.1, starting at a configurable byte offset. Output is packed 8 bits per AXI-Stream beat, i.e. 4 QPSK DMRS symbols per beat. It feeds the `dmrs_in` port of `wn_pdcchrx_modulationremoval` directly.

## Interface
Parameters:
- `NC`, 1600: Gold sequence warm-up length in bits. Must be a multiple of 8; 0 is legal.
- `LEN_W`, 12: width of the byte-count and offset fields.

Ports:
- `clk`, in, 1: single clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `cfg_in_tdata`, in, 64: configuration word.
  - [30:0] cinit.
  - [43:32] skip_bytes (LEN_W).
  - [59:48] num_bytes (LEN_W).
  - All other bits are ignored.
- `cfg_in_tvalid`, in, 1: configuration valid.
- `cfg_in_tready`, out, 1: configuration accepted.
- `dmrs_out_tdata`, out, 8: bit k = c(n+k), where n = 8·(skip_bytes + beat index).
- `dmrs_out_tvalid`, out, 1: output beat valid.
- `dmrs_out_tready`, in, 1: downstream ready.
- `dmrs_out_tlast`, out, 1: asserted on the last byte of the configuration.

## Operation
- Registers:
  - x1[30:0] and x2[30:0]; bit i holds x(m+i) for the current sequence index m.
  - skip counter and byte counter, LEN_W each.
- FSM states: IDLE, WARMUP, SKIP, STREAM.
- IDLE:
  - `cfg_in_tready` = 1.
  - On handshake: x1 <= 31'h1, x2 <= cinit, latch num_bytes and skip_bytes.
  - Next state:
    - IDLE if num_bytes == 0 (configuration consumed, no output beat).
    - Otherwise WARMUP if NC > 0, else SKIP if skip_bytes > 0, else STREAM.
- Advance-8 step, single cycle, computed in parallel for j = 0..7 from the current registers:
  - x1(m+31+j) = x1(m+3+j) ^ x1(m+j)
  - x2(m+31+j) = x2(m+3+j) ^ x2(m+2+j) ^ x2(m+1+j) ^ x2(m+j)
  - Registers shift right by 8 and the 8 new bits enter at [30:23].
- WARMUP: advance-8 every cycle for NC/8 cycles, then go to SKIP (if skip_bytes > 0) or STREAM.
- SKIP: advance-8 every cycle for skip_bytes cycles, then go to STREAM.
- STREAM:
  - `dmrs_out_tdata` = x1[7:0] ^ x2[7:0].
  - `dmrs_out_tvalid` = 1.
  - On handshake: advance-8 and increment the byte counter.
  - On the handshake of the beat with tlast set: go to IDLE.
- `dmrs_out_tlast` = 1 when byte counter == num_bytes − 1.
- Counters are LEN_W wide. num_bytes = 2^LEN_W − 1 is the maximum.
- All outputs are driven from flops or state decode only. No combinational path from `dmrs_out_tready` to `cfg_in_tready`.

## Timing
- Reset values:
  - `cfg_in_tready` = 0 while `rstn` is low, and 1 from the first clock edge after release.
  - `dmrs_out_tvalid` = 0, `dmrs_out_tlast` = 0, `dmrs_out_tdata` = 8'h00.
  - FSM = IDLE, x1 = x2 = 0.
- Latency: configuration handshake at edge T → first `dmrs_out_tvalid` at edge T + 1 + NC/8 + skip_bytes. With NC = 1600 and skip_bytes = 0 this is T + 201.
- Throughput: 1 byte per cycle while `dmrs_out_tready` = 1.
- A configuration is accepted only in IDLE. The earliest next handshake is the cycle after the final tlast handshake, giving num_bytes + 1 + NC/8 + skip_bytes cycles per configuration at full rate.
- Backpressure: tdata, tvalid and tlast stay stable while tvalid = 1 and tready = 0. The LFSRs do not advance.
- Reset asserted mid-WARMUP, mid-SKIP or mid-STREAM: state clears immediately and asynchronously, the partial sequence is dropped, and no tlast is emitted.

## Structure
- Package `wn_pdcchrx_pkg`:
  - FSM state enum.
  - cfg field bit positions.
  - `WN_DMRS_NC` default constant.
  - Function `gold_adv8(x1, x2)` returning the advanced pair.
- Sub-module `wn_gold_adv8`: combinational advance-8 of the x1/x2 pair. It is shared by the WARMUP, SKIP and STREAM paths.

## Test plan
- NC = 0, cinit = 0, skip = 0, num_bytes = 4, tready = 1 → beats 8'h01, 8'h00, 8'h00, 8'h80. tlast only on the 4th beat. Then `cfg_in_tready` = 1 again.
- NC = 1600, cinit = 31'h12345, num_bytes = 18 → first tvalid exactly 201 cycles after the handshake. All 18 bytes match the C/Python golden c(n).
- Same cinit with skip_bytes = 5 and num_bytes = 13 → output equals bytes 5..17 of the previous run. First tvalid at handshake + 206.
- Random tready (≈30 % low) with back-to-back configurations → data identical to the full-rate run. tdata stable during stalls. No configuration accepted outside IDLE.
- num_bytes = 0 → configuration consumed, no beats, tready high the next cycle. A following configuration with num_bytes = 2 produces exactly 2 beats.
- `rstn` pulsed low mid-STREAM at byte 3 of 10 → tvalid = 0 asynchronously. A new configuration after release restarts from c(8·skip) with correct data.

Source files
------------

// File: rtl/wn_pdcchrx_dmrsgen_pkg.sv
// Shared types, cfg field positions and the Gold advance-8 step
// for the PDCCH DMRS sequence generator.
package wn_pdcchrx_pkg;

    localparam int WN_DMRS_NC = 1600;

    localparam int CFG_CINIT_LSB = 0;
    localparam int CFG_CINIT_W   = 31;
    localparam int CFG_SKIP_LSB  = 32;
    localparam int CFG_NUM_LSB   = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SKIP   = 2'd2,
        ST_STREAM = 2'd3
    } dmrs_state_t;

    typedef struct packed {
        logic [30:0] x1;
        logic [30:0] x2;
    } gold_pair_t;

    // Eight new bits depend only on x(m)..x(m+10), so all of them are
    // available from the current register contents in one step.
    function automatic gold_pair_t gold_adv8(input logic [30:0] x1,
                                             input logic [30:0] x2);
        gold_pair_t r;
        logic [7:0] n1;
        logic [7:0] n2;
        for (int j = 0; j < 8; j++) begin
            n1[j] = x1[j+3] ^ x1[j];
            n2[j] = x2[j+3] ^ x2[j+2] ^ x2[j+1] ^ x2[j];
        end
        r.x1 = {n1, x1[30:8]};
        r.x2 = {n2, x2[30:8]};
        return r;
    endfunction

endpackage

// File: rtl/wn_pdcchrx_dmrsgen_if.sv
// AXI-Stream style channel used for both the cfg input and the DMRS output.
interface wn_pdcchrx_dmrsgen_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/wn_pdcchrx_dmrsgen_adv8.sv
// Combinational advance-8 of the x1/x2 Gold LFSR pair.
module wn_gold_adv8
    import wn_pdcchrx_pkg::*;
(
    input  logic [30:0] i_x1,
    input  logic [30:0] i_x2,
    output logic [30:0] o_x1,
    output logic [30:0] o_x2
);

    gold_pair_t w_nxt;

    assign w_nxt = gold_adv8(i_x1, i_x2);
    assign o_x1  = w_nxt.x1;
    assign o_x2  = w_nxt.x2;

endmodule

// File: rtl/wn_pdcchrx_dmrsgen.sv
// PDCCH DMRS Gold sequence generator: one cfg per candidate, c(n) packed
// 8 bits per output beat starting at byte skip_bytes.
//
//   state     | meaning
//   ST_IDLE   | cfg_in ready, waiting for a candidate
//   ST_WARMUP | discarding the first NC bits, 8 per cycle
//   ST_SKIP   | discarding skip_bytes bytes, one per cycle
//   ST_STREAM | presenting c(n) bytes, advancing on each handshake
module wn_pdcchrx_dmrsgen
    import wn_pdcchrx_pkg::*;
#(
    parameter int NC    = WN_DMRS_NC,
    parameter int LEN_W = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    wn_pdcchrx_dmrsgen_if.slave  cfg_in,
    wn_pdcchrx_dmrsgen_if.master dmrs_out
);

    localparam int WARM_CYC = NC / 8;
    localparam int WW       = (WARM_CYC < 2) ? 1 : $clog2(WARM_CYC + 1);

    dmrs_state_t r_state;
    dmrs_state_t w_nxt_state;

    logic              r_rdy;
    logic [30:0]       r_x1;
    logic [30:0]       r_x2;
    logic [LEN_W-1:0]  r_num;
    logic [LEN_W-1:0]  r_skip;
    logic [LEN_W-1:0]  r_bcnt;
    logic [WW-1:0]     r_warm;

    logic              w_cfg_hs;
    logic              w_out_hs;
    logic              w_last;
    logic              w_adv;
    logic              w_stream;
    logic [LEN_W-1:0]  w_cfg_num;
    logic [LEN_W-1:0]  w_cfg_skip;
    logic [30:0]       w_cfg_cinit;
    logic [30:0]       w_adv_x1;
    logic [30:0]       w_adv_x2;
    logic              w_unused_cfg;

    assign w_cfg_cinit  = cfg_in.tdata[CFG_CINIT_LSB +: CFG_CINIT_W];
    assign w_cfg_skip   = cfg_in.tdata[CFG_SKIP_LSB +: LEN_W];
    assign w_cfg_num    = cfg_in.tdata[CFG_NUM_LSB +: LEN_W];
    assign w_unused_cfg = ^{cfg_in.tdata, cfg_in.tlast};

    assign w_stream = (r_state == ST_STREAM);
    assign w_cfg_hs = cfg_in.tvalid && cfg_in.tready;
    assign w_out_hs = w_stream && dmrs_out.tready;
    assign w_last   = (r_bcnt == (r_num - LEN_W'(1)));

    wn_gold_adv8 u_adv8 (
        .i_x1 (r_x1),
        .i_x2 (r_x2),
        .o_x1 (w_adv_x1),
        .o_x2 (w_adv_x2)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_hs) begin
                    if (w_cfg_num == '0)
                        w_nxt_state = ST_IDLE;
                    else if (WARM_CYC > 0)
                        w_nxt_state = ST_WARMUP;
                    else if (w_cfg_skip != '0)
                        w_nxt_state = ST_SKIP;
                    else
                        w_nxt_state = ST_STREAM;
                end
            end
            ST_WARMUP: begin
                w_adv = 1'b1;
                if (r_warm == WW'(1))
                    w_nxt_state = (r_skip != '0) ? ST_SKIP : ST_STREAM;
            end
            ST_SKIP: begin
                w_adv = 1'b1;
                if (r_skip == LEN_W'(1))
                    w_nxt_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_out_hs) begin
                    w_adv = 1'b1;
                    if (w_last)
                        w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt_state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy  <= 1'b0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_num  <= '0;
            r_skip <= '0;
            r_bcnt <= '0;
            r_warm <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_cfg_hs) begin
                r_x1   <= 31'h1;
                r_x2   <= w_cfg_cinit;
                r_num  <= w_cfg_num;
                r_skip <= w_cfg_skip;
                r_bcnt <= '0;
                r_warm <= WW'(WARM_CYC);
            end else if (w_adv) begin
                r_x1 <= w_adv_x1;
                r_x2 <= w_adv_x2;
            end
            if (r_state == ST_WARMUP)
                r_warm <= r_warm - WW'(1);
            if (r_state == ST_SKIP)
                r_skip <= r_skip - LEN_W'(1);
            if (w_out_hs)
                r_bcnt <= r_bcnt + LEN_W'(1);
        end
    end

    // Readiness is held off until the first edge after reset release.
    assign cfg_in.tready   = r_rdy && (r_state == ST_IDLE);
    assign dmrs_out.tvalid = w_stream;
    assign dmrs_out.tlast  = w_stream && w_last;
    assign dmrs_out.tdata  = w_stream ? (r_x1[7:0] ^ r_x2[7:0]) : 8'h00;

endmodule

// File: tb/tb_wn_pdcchrx_dmrsgen.sv
// Scoreboard bench: drivers queue expected beats, monitors pop and compare.
module tb_wn_pdcchrx_dmrsgen;
    import wn_pdcchrx_pkg::*;

    localparam int NC1 = 1600;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wn_pdcchrx_dmrsgen_if #(.DW(64)) cfg0 ();
    wn_pdcchrx_dmrsgen_if #(.DW(64)) cfg1 ();
    wn_pdcchrx_dmrsgen_if #(.DW(8))  out0 ();
    wn_pdcchrx_dmrsgen_if #(.DW(8))  out1 ();

    wn_pdcchrx_dmrsgen #(.NC(0), .LEN_W(12)) u_dut0 (
        .clk(clk), .rstn(rstn), .cfg_in(cfg0), .dmrs_out(out0));
    wn_pdcchrx_dmrsgen #(.NC(NC1), .LEN_W(12)) u_dut1 (
        .clk(clk), .rstn(rstn), .cfg_in(cfg1), .dmrs_out(out1));

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    ncyc  = 0;
    int    pops1 = 0;
    int    exp_first1 = -1;
    logic  busy1  = 1'b0;
    logic  rnd_en = 1'b0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: byte idx of c(n) after nc warm-up bits.
    function automatic logic [7:0] gold_byte(input logic [30:0] ci, input int nc, input int idx);
        logic [30:0] a;
        logic [30:0] b;
        logic [7:0]  r;
        a = 31'h1;
        b = ci;
        for (int i = 0; i < nc + 8 * idx; i++) begin
            a = {a[3] ^ a[0], a[30:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
        for (int k = 0; k < 8; k++) r[k] = a[k] ^ b[k];
        return r;
    endfunction

    function automatic logic [63:0] mk_cfg(input logic [30:0] ci, input int sk, input int nb);
        logic [11:0] s;
        logic [11:0] n;
        s = sk[11:0];
        n = nb[11:0];
        return {4'h0, n, 4'h0, s, 1'b0, ci};
    endfunction

    always @(negedge clk) begin : mon0
        beat_t e;
        if (rstn && out0.tvalid && out0.tready) begin
            if (q0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL dut0_unexpected_beat: got data 0x%0h with no beat expected", out0.tdata);
            end else begin
                e = q0.pop_front();
                check("dut0_data", {24'h0, out0.tdata}, {24'h0, e.data});
                check("dut0_last", {31'h0, out0.tlast}, {31'h0, e.last});
            end
        end
    end

    always @(negedge clk) begin : mon1
        beat_t      e;
        logic       stall;
        logic [8:0] prev;
        if (!rstn) begin
            stall = 1'b0;
        end else begin
            if (busy1) check("dut1_cfg_ready_while_busy", {31'h0, cfg1.tready}, 32'h0);
            if (stall)
                check("dut1_stall_stable", {22'h0, out1.tvalid, out1.tlast, out1.tdata}, {22'h0, 1'b1, prev});
            if (out1.tvalid && exp_first1 >= 0) begin
                check("dut1_first_valid_edge", ncyc + 1, exp_first1);
                exp_first1 = -1;
            end
            if (out1.tvalid && out1.tready) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dut1_unexpected_beat: got data 0x%0h with no beat expected", out1.tdata);
                end else begin
                    e = q1.pop_front();
                    check("dut1_data", {24'h0, out1.tdata}, {24'h0, e.data});
                    check("dut1_last", {31'h0, out1.tlast}, {31'h0, e.last});
                    pops1++;
                    if (e.last) busy1 = 1'b0;
                end
            end
            stall = out1.tvalid && !out1.tready;
            prev  = {out1.tlast, out1.tdata};
        end
    end

    initial begin
        out1.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out1.tready = rnd_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    task automatic send0(input logic [30:0] ci, input int sk, input int nb, input logic hand);
        int w;
        w = 0;
        @(posedge clk); #1;
        cfg0.tdata  = mk_cfg(ci, sk, nb);
        cfg0.tvalid = 1'b1;
        do begin @(negedge clk); w++; end while (!cfg0.tready && w < 5000);
        if (!cfg0.tready) begin
            n_cmp++; n_err++;
            $display("FAIL dut0_cfg_accept_timeout: ready stayed 0 for %0d cycles", w);
        end else if (hand) begin
            q0.push_back('{data: 8'h01, last: 1'b0});
            q0.push_back('{data: 8'h00, last: 1'b0});
            q0.push_back('{data: 8'h00, last: 1'b0});
            q0.push_back('{data: 8'h80, last: 1'b1});
        end else begin
            for (int k = 0; k < nb; k++)
                q0.push_back('{data: gold_byte(ci, 0, sk + k), last: (k == nb - 1)});
        end
        @(posedge clk); #1;
        cfg0.tvalid = 1'b0;
    endtask

    task automatic send1(input logic [30:0] ci, input int sk, input int nb);
        int w;
        w = 0;
        @(posedge clk); #1;
        cfg1.tdata  = mk_cfg(ci, sk, nb);
        cfg1.tvalid = 1'b1;
        do begin @(negedge clk); w++; end while (!cfg1.tready && w < 5000);
        if (!cfg1.tready) begin
            n_cmp++; n_err++;
            $display("FAIL dut1_cfg_accept_timeout: ready stayed 0 for %0d cycles", w);
            cfg1.tvalid = 1'b0;
            return;
        end
        for (int k = 0; k < nb; k++)
            q1.push_back('{data: gold_byte(ci, NC1, sk + k), last: (k == nb - 1)});
        if (nb > 0) exp_first1 = ncyc + 2 + NC1 / 8 + sk;
        @(posedge clk); #1;
        cfg1.tvalid = 1'b0;
        if (nb > 0) busy1 = 1'b1;
    endtask

    task automatic drain0();
        int w;
        w = 0;
        while (q0.size() != 0 && w < 5000) begin @(negedge clk); w++; end
        if (q0.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut0_drain_timeout: %0d beats still pending", q0.size());
            q0.delete();
        end
    endtask

    task automatic drain1();
        int w;
        w = 0;
        while ((q1.size() != 0 || busy1) && w < 20000) begin @(negedge clk); w++; end
        if (q1.size() != 0 || busy1) begin
            n_cmp++; n_err++;
            $display("FAIL dut1_drain_timeout: %0d beats still pending", q1.size());
            q1.delete();
            busy1 = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        cfg0.tdata = '0; cfg0.tvalid = 1'b0; cfg0.tlast = 1'b0;
        cfg1.tdata = '0; cfg1.tvalid = 1'b0; cfg1.tlast = 1'b0;
        out0.tready = 1'b1;

        #23;
        check("rst_cfg0_ready", {31'h0, cfg0.tready}, 32'h0);
        check("rst_cfg1_ready", {31'h0, cfg1.tready}, 32'h0);
        check("rst_out1_valid", {31'h0, out1.tvalid}, 32'h0);
        check("rst_out1_last",  {31'h0, out1.tlast},  32'h0);
        check("rst_out1_data",  {24'h0, out1.tdata},  32'h0);
        check("rst_out0_valid", {31'h0, out0.tvalid}, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        check("rel_cfg0_ready", {31'h0, cfg0.tready}, 32'h1);
        check("rel_cfg1_ready", {31'h0, cfg1.tready}, 32'h1);

        // NC = 0, cinit = 0: hand-derived 01 00 00 80
        send0(31'h0, 0, 4, 1'b1);
        drain0();
        @(negedge clk);
        check("dut0_ready_after_last", {31'h0, cfg0.tready}, 32'h1);
        send0(31'h12345, 1, 3, 1'b0);
        drain0();

        // NC = 1600 full rate, then skip 5
        send1(31'h12345, 0, 18);
        drain1();
        send1(31'h12345, 5, 13);
        drain1();

        // random backpressure, back-to-back configurations
        rnd_en = 1'b1;
        send1(31'h12345, 0, 18);
        send1(31'h12345, 5, 13);
        send1(31'h5a5a5a5, 3, 7);
        drain1();
        rnd_en = 1'b0;
        @(posedge clk); #2;

        // empty configuration then a 2-beat one
        send1(31'h777, 0, 0);
        @(negedge clk);
        check("dut1_ready_after_empty", {31'h0, cfg1.tready}, 32'h1);
        base = pops1;
        send1(31'h777, 0, 2);
        drain1();
        check("dut1_two_beats", pops1 - base, 2);

        // asynchronous reset in the middle of a stream
        base = pops1;
        send1(31'h0abcdef, 2, 10);
        w = 0;
        while (pops1 < base + 3 && w < 5000) begin @(posedge clk); w++; end
        check("dut1_reached_byte3", pops1 - base, 3);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out1.tvalid}, 32'h0);
        check("async_rst_last",  {31'h0, out1.tlast},  32'h0);
        check("async_rst_ready", {31'h0, cfg1.tready}, 32'h0);
        check("async_rst_data",  {24'h0, out1.tdata},  32'h0);
        q1.delete();
        busy1 = 1'b0;
        exp_first1 = -1;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        send1(31'h0abcdef, 2, 4);
        drain1();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
